// File: rtl/rv32imc_types.sv
// Shared types for the rv32imc memory-side blocks: arbiter FSM state and the
// request record held in the arbiter's pending registers.
package rv32imc_types;

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD
  } mem_arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_req_buf.sv
// Pending holding register for one requester of mem_port_arbiter.
// Capture takes precedence over clear.
module mem_arb_req_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] cap_addr,
  input  logic [3:0]  cap_rmask,
  input  logic [3:0]  cap_wmask,
  input  logic [31:0] cap_wdata,
  output logic        valid,
  output logic [31:0] addr,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask,
  output logic [31:0] wdata
);
  import rv32imc_types::*;

  logic     valid_q;
  mem_req_t req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else if (capture) begin
      valid_q <= 1'b1;
      req_q   <= '{addr: cap_addr, rmask: cap_rmask, wmask: cap_wmask, wdata: cap_wdata};
    end else if (clear) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign addr  = req_q.addr;
  assign rmask = req_q.rmask;
  assign wmask = req_q.wmask;
  assign wdata = req_q.wdata;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one non-pipelined memory port between imem and dmem, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise dmem has fixed priority.
module mem_port_arbiter
  import rv32imc_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  mem_arb_state_t state_q, state_d;

  logic        i_live, d_live, i_live_ok, d_live_ok, i_has, d_has, d_wins;
  logic        i_pend_valid, d_pend_valid, i_cap, d_cap, i_clr, d_clr, issue_i, issue_d;
  logic [31:0] i_pend_addr, i_pend_wdata, d_pend_addr, d_pend_wdata;
  logic [3:0]  i_pend_rmask, i_pend_wmask, d_pend_rmask, d_pend_wmask;
  mem_req_t    i_live_req, d_live_req, i_pend_req, d_pend_req, i_cand_req, d_cand_req;
  mem_req_t    issue_req;

  assign i_live     = |imem_rmask;
  assign d_live     = (|dmem_rmask) || (|dmem_wmask);
  assign i_live_req = '{addr: imem_addr, rmask: imem_rmask, wmask: 4'h0, wdata: 32'h0};
  assign d_live_req = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};
  assign i_pend_req = '{addr: i_pend_addr, rmask: i_pend_rmask, wmask: i_pend_wmask,
                        wdata: i_pend_wdata};
  assign d_pend_req = '{addr: d_pend_addr, rmask: d_pend_rmask, wmask: d_pend_wmask,
                        wdata: d_pend_wdata};

  // A live request is dropped if its requester already has one pending or in flight.
  assign i_live_ok  = i_live && !i_pend_valid && (state_q != StBusyI);
  assign d_live_ok  = d_live && !d_pend_valid && (state_q != StBusyD);
  assign i_has      = i_live_ok || i_pend_valid;
  assign d_has      = d_live_ok || d_pend_valid;
  assign i_cand_req = i_live_ok ? i_live_req : i_pend_req;
  assign d_cand_req = d_live_ok ? d_live_req : d_pend_req;

`ifdef MEM_ARB_RR_EN
  logic last_grant_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_d_q <= 1'b0;
    end else if (issue_i || issue_d) begin
      last_grant_d_q <= issue_d;
    end
  end

  assign d_wins = !last_grant_d_q;
`else
  assign d_wins = 1'b1;
`endif

  mem_arb_req_buf u_imem_buf (
    .clk       (clk),
    .rst       (rst),
    .capture   (i_cap),
    .clear     (i_clr),
    .cap_addr  (i_live_req.addr),
    .cap_rmask (i_live_req.rmask),
    .cap_wmask (i_live_req.wmask),
    .cap_wdata (i_live_req.wdata),
    .valid     (i_pend_valid),
    .addr      (i_pend_addr),
    .rmask     (i_pend_rmask),
    .wmask     (i_pend_wmask),
    .wdata     (i_pend_wdata)
  );

  mem_arb_req_buf u_dmem_buf (
    .clk       (clk),
    .rst       (rst),
    .capture   (d_cap),
    .clear     (d_clr),
    .cap_addr  (d_live_req.addr),
    .cap_rmask (d_live_req.rmask),
    .cap_wmask (d_live_req.wmask),
    .cap_wdata (d_live_req.wdata),
    .valid     (d_pend_valid),
    .addr      (d_pend_addr),
    .rmask     (d_pend_rmask),
    .wmask     (d_pend_wmask),
    .wdata     (d_pend_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    issue_i   = 1'b0;
    issue_d   = 1'b0;
    i_cap     = 1'b0;
    d_cap     = 1'b0;
    i_clr     = 1'b0;
    d_clr     = 1'b0;
    imem_resp = 1'b0;
    dmem_resp = 1'b0;
    case (state_q)
      StIdle: begin
        if (d_has && (!i_has || d_wins)) begin
          issue_d = 1'b1;
          d_clr   = d_pend_valid;
          i_cap   = i_live_ok;
          state_d = StBusyD;
        end else if (i_has) begin
          issue_i = 1'b1;
          i_clr   = i_pend_valid;
          d_cap   = d_live_ok;
          state_d = StBusyI;
        end
      end
      StBusyI, StBusyD: begin
        i_cap = i_live_ok;
        d_cap = d_live_ok;
        if (mem_resp) begin
          imem_resp = (state_q == StBusyI);
          dmem_resp = (state_q == StBusyD);
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Outputs are forced quiet while reset is held, not just after it releases.
    if (rst) begin
      issue_i   = 1'b0;
      issue_d   = 1'b0;
      imem_resp = 1'b0;
      dmem_resp = 1'b0;
    end
  end

  assign issue_req  = issue_d ? d_cand_req : (issue_i ? i_cand_req : '0);
  assign mem_addr   = issue_req.addr;
  assign mem_wdata  = issue_req.wdata;
  assign mem_rmask  = issue_req.rmask;
  assign mem_wmask  = issue_req.wmask;
  assign imem_rdata = rst ? 32'h0 : mem_rdata;
  assign dmem_rdata = rst ? 32'h0 : mem_rdata;

  a_imem_protocol: assert property (@(posedge clk) disable iff (rst)
    i_live |-> !(i_pend_valid || state_q == StBusyI));
  a_dmem_protocol: assert property (@(posedge clk) disable iff (rst)
    d_live |-> !(d_pend_valid || state_q == StBusyD || (|dmem_rmask && |dmem_wmask)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle table, reset sequence, random scoreboard run.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr = '0, imem_rdata;
  logic [3:0]  imem_rmask = '0;
  logic        imem_resp;
  logic [31:0] dmem_addr = '0, dmem_wdata = '0, dmem_rdata;
  logic [3:0]  dmem_rmask = '0, dmem_wmask = '0;
  logic        dmem_resp;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_rmask, mem_wmask;
  logic [31:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rmask (imem_rmask),
    .imem_rdata (imem_rdata),
    .imem_resp  (imem_resp),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rmask  (mem_rmask),
    .mem_wmask  (mem_wmask),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  i_rmask;
    logic [31:0] i_addr;
    logic [3:0]  d_rmask;
    logic [3:0]  d_wmask;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        m_resp;
    logic [31:0] m_rdata;
    logic [3:0]  e_rmask;
    logic [3:0]  e_wmask;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_iresp;
    logic        e_dresp;
  } vec_t;

  function automatic vec_t v(string name, logic [3:0] irm, logic [31:0] ia, logic [3:0] drm,
                             logic [3:0] dwm, logic [31:0] da, logic [31:0] dwd, logic mr,
                             logic [31:0] mrd, logic [3:0] erm, logic [3:0] ewm,
                             logic [31:0] ea, logic [31:0] ewd, logic eir, logic edr);
    vec_t t;
    t.name = name; t.rst = 1'b0;
    t.i_rmask = irm; t.i_addr = ia; t.d_rmask = drm; t.d_wmask = dwm;
    t.d_addr = da; t.d_wdata = dwd; t.m_resp = mr; t.m_rdata = mrd;
    t.e_rmask = erm; t.e_wmask = ewm; t.e_addr = ea; t.e_wdata = ewd;
    t.e_iresp = eir; t.e_dresp = edr;
    return t;
  endfunction

  // One cycle: drive just after the rising edge, compare the combinational outputs mid-cycle.
  task automatic apply(input vec_t t);
    logic [31:0] erd;
    @(posedge clk);
    #1;
    rst = t.rst;
    imem_rmask = t.i_rmask; imem_addr = t.i_addr;
    dmem_rmask = t.d_rmask; dmem_wmask = t.d_wmask; dmem_addr = t.d_addr; dmem_wdata = t.d_wdata;
    mem_resp = t.m_resp; mem_rdata = t.m_rdata;
    #4;
    erd = t.rst ? 32'h0 : t.m_rdata;
    checks++;
    if ({mem_rmask, mem_wmask, mem_addr, mem_wdata} !== {t.e_rmask, t.e_wmask, t.e_addr, t.e_wdata})
    begin
      errors++;
      $display("FAIL %s issue: got rm=%h wm=%h addr=%h wd=%h, want rm=%h wm=%h addr=%h wd=%h",
               t.name, mem_rmask, mem_wmask, mem_addr, mem_wdata,
               t.e_rmask, t.e_wmask, t.e_addr, t.e_wdata);
    end
    checks++;
    if ({imem_resp, dmem_resp, imem_rdata, dmem_rdata} !== {t.e_iresp, t.e_dresp, erd, erd}) begin
      errors++;
      $display("FAIL %s resp: got iresp=%b dresp=%b ird=%h drd=%h, want iresp=%b dresp=%b rd=%h",
               t.name, imem_resp, dmem_resp, imem_rdata, dmem_rdata, t.e_iresp, t.e_dresp, erd);
    end
  endtask

  function automatic logic [31:0] mem_model(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C3C_A5A5;
  endfunction

  vec_t tbl[$];
  vec_t t;

  // Random-phase state
  localparam int unsigned NumReq = 1000;
  logic [31:0] i_exp_q[$], d_exp_q[$];
  logic [31:0] i_addr_c, d_addr_c, d_wd_c, cur_addr, exp_rd;
  logic [3:0]  d_rm_c, d_wm_c;
  bit          i_wait, d_wait, i_iss, d_iss, busy, own_d, resp_now, exp_i, exp_d;
  int          cnt, req_cnt, rsp_cnt, cyc;

  initial begin
    // Reset held with live stimulus: everything quiet.
    t = v("reset_hold", 4'hF, 32'h6000_0000, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF,
          4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    t.rst = 1'b1;
    apply(t);

    tbl.push_back(v("idle0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("fetch_issue", 4'hF, 32'h6000_0000, 0, 0, 0, 0, 0, 0,
                    4'hF, 0, 32'h6000_0000, 0, 0, 0));
    tbl.push_back(v("fetch_wait1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("fetch_wait2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("fetch_resp", 0, 0, 0, 0, 0, 0, 1, 32'h0000_0013, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v("idle1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("contend_store", 4'hF, 32'h6000_0004, 0, 4'h3, 32'h6000_1000, 32'h0000_BEEF,
                    0, 0, 0, 4'h3, 32'h6000_1000, 32'h0000_BEEF, 0, 0));
    tbl.push_back(v("store_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("store_resp", 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v("pend_fetch_issue", 0, 0, 0, 0, 0, 0, 0, 0,
                    4'hF, 0, 32'h6000_0004, 0, 0, 0));
    tbl.push_back(v("fetch2_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("load_in_busy_i", 0, 0, 4'h1, 0, 32'h6000_2000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("fetch2_resp", 0, 0, 0, 0, 0, 0, 1, 32'h0000_0093, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v("pend_load_issue", 0, 0, 0, 0, 0, 0, 0, 0,
                    4'h1, 0, 32'h6000_2000, 0, 0, 0));
    tbl.push_back(v("load_resp", 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v("stale_resp", 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_0000, 0, 0, 0, 0, 0, 0));
`ifdef MEM_ARB_RR_EN
    tbl.push_back(v("rr_contend", 4'hF, 32'h6000_0008, 4'hF, 0, 32'h6000_3000, 0, 0, 0,
                    4'hF, 0, 32'h6000_0008, 0, 0, 0));
    tbl.push_back(v("rr_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("rr_resp1", 0, 0, 0, 0, 0, 0, 1, 32'h55, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v("rr_second", 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 32'h6000_3000, 0, 0, 0));
    tbl.push_back(v("rr_resp2", 0, 0, 0, 0, 0, 0, 1, 32'h66, 0, 0, 0, 0, 0, 1));
`else
    tbl.push_back(v("fp_contend", 4'hF, 32'h6000_0008, 4'hF, 0, 32'h6000_3000, 0, 0, 0,
                    4'hF, 0, 32'h6000_3000, 0, 0, 0));
    tbl.push_back(v("fp_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("fp_resp1", 0, 0, 0, 0, 0, 0, 1, 32'h55, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v("fp_second", 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 32'h6000_0008, 0, 0, 0));
    tbl.push_back(v("fp_resp2", 0, 0, 0, 0, 0, 0, 1, 32'h66, 0, 0, 0, 0, 1, 0));
`endif
    tbl.push_back(v("idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) apply(tbl[i]);

    // Reset mid-BUSY_D with a fetch pending.
    apply(v("rst_store", 0, 0, 0, 4'hF, 32'h6000_4000, 32'h1, 0, 0,
            0, 4'hF, 32'h6000_4000, 32'h1, 0, 0));
    apply(v("rst_fetch_pend", 4'hF, 32'h6000_000C, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t = v("rst_pulse", 0, 0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0);
    t.rst = 1'b1;
    apply(t);
    apply(v("rst_stale_resp", 0, 0, 0, 0, 0, 0, 1, 32'h1111, 0, 0, 0, 0, 0, 0));
    apply(v("rst_pend_lost", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(v("rst_fetch_new", 4'hF, 32'h6000_0010, 0, 0, 0, 0, 0, 0,
            4'hF, 0, 32'h6000_0010, 0, 0, 0));
    apply(v("rst_fetch_resp", 0, 0, 0, 0, 0, 0, 1, 32'h2222, 0, 0, 0, 0, 1, 0));

    // Random back-to-back traffic against a 1-5 cycle memory model.
    i_wait = 0; d_wait = 0; i_iss = 0; d_iss = 0; busy = 0; own_d = 0;
    cnt = 0; req_cnt = 0; rsp_cnt = 0; cyc = 0;
    i_addr_c = '0; d_addr_c = '0; d_wd_c = '0; d_rm_c = '0; d_wm_c = '0; cur_addr = '0;
    while (rsp_cnt < NumReq && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      imem_rmask = '0; dmem_rmask = '0; dmem_wmask = '0; mem_resp = 1'b0;
      mem_rdata = $urandom; imem_addr = $urandom; dmem_addr = $urandom; dmem_wdata = $urandom;
      resp_now = 1'b0;
      if (busy) begin
        if (cnt == 1) begin
          mem_resp = 1'b1;
          mem_rdata = mem_model(cur_addr);
          resp_now = 1'b1;
        end else begin
          cnt--;
        end
      end
      if (!i_wait && req_cnt < NumReq && $urandom_range(0, 2) == 0) begin
        i_addr_c = 32'h6000_0000 | (32'($urandom_range(0, 16383)) << 2);
        imem_addr = i_addr_c; imem_rmask = 4'hF;
        i_wait = 1'b1; i_iss = 1'b0;
        i_exp_q.push_back(mem_model(i_addr_c));
        req_cnt++;
      end
      if (!d_wait && req_cnt < NumReq && $urandom_range(0, 2) == 0) begin
        d_addr_c = 32'h7000_0000 | (32'($urandom_range(0, 16383)) << 2);
        if ($urandom_range(0, 1) == 1) begin
          d_rm_c = 4'($urandom_range(1, 15)); d_wm_c = 4'h0; d_wd_c = 32'h0;
        end else begin
          d_rm_c = 4'h0; d_wm_c = 4'($urandom_range(1, 15)); d_wd_c = $urandom;
        end
        dmem_addr = d_addr_c; dmem_rmask = d_rm_c; dmem_wmask = d_wm_c; dmem_wdata = d_wd_c;
        d_wait = 1'b1; d_iss = 1'b0;
        d_exp_q.push_back(mem_model(d_addr_c));
        req_cnt++;
      end
      #4;
      if (mem_rmask != 4'h0 || mem_wmask != 4'h0) begin
        checks++;
        if (busy) begin
          errors++;
          $display("FAIL rnd_overlap: got issue rm=%h wm=%h while outstanding, want none",
                   mem_rmask, mem_wmask);
        end
        checks++;
        if (d_wait && !d_iss &&
            {mem_addr, mem_rmask, mem_wmask, mem_wdata} == {d_addr_c, d_rm_c, d_wm_c, d_wd_c}) begin
          own_d = 1'b1; d_iss = 1'b1;
        end else if (i_wait && !i_iss &&
            {mem_addr, mem_rmask, mem_wmask, mem_wdata} == {i_addr_c, 4'hF, 4'h0, 32'h0}) begin
          own_d = 1'b0; i_iss = 1'b1;
        end else begin
          errors++;
          $display("FAIL rnd_issue: got addr=%h rm=%h wm=%h wd=%h, want an unissued request",
                   mem_addr, mem_rmask, mem_wmask, mem_wdata);
        end
        busy = 1'b1;
        cnt = $urandom_range(1, 5);
        cur_addr = mem_addr;
      end
      exp_i = resp_now && !own_d;
      exp_d = resp_now && own_d;
      checks++;
      if (imem_resp !== exp_i || dmem_resp !== exp_d) begin
        errors++;
        $display("FAIL rnd_resp_route: got iresp=%b dresp=%b, want iresp=%b dresp=%b",
                 imem_resp, dmem_resp, exp_i, exp_d);
      end
      if (resp_now) begin
        checks++;
        if (own_d) begin
          exp_rd = (d_exp_q.size() > 0) ? d_exp_q.pop_front() : 32'hX;
          if (dmem_rdata !== exp_rd) begin
            errors++;
            $display("FAIL rnd_dmem_rdata: got %h, want %h", dmem_rdata, exp_rd);
          end
          d_wait = 1'b0;
        end else begin
          exp_rd = (i_exp_q.size() > 0) ? i_exp_q.pop_front() : 32'hX;
          if (imem_rdata !== exp_rd) begin
            errors++;
            $display("FAIL rnd_imem_rdata: got %h, want %h", imem_rdata, exp_rd);
          end
          i_wait = 1'b0;
        end
        rsp_cnt++;
        busy = 1'b0;
      end
    end
    checks++;
    if (rsp_cnt != int'(NumReq) || req_cnt != rsp_cnt) begin
      errors++;
      $display("FAIL rnd_complete: got %0d responses for %0d requests in %0d cycles, want %0d",
               rsp_cnt, req_cnt, cyc, NumReq);
    end
    checks++;
    if (i_exp_q.size() != 0 || d_exp_q.size() != 0) begin
      errors++;
      $display("FAIL rnd_drain: got %0d/%0d unanswered, want 0/0", i_exp_q.size(), d_exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
